// File: rtl/regfile_wb_read_pkg.sv
// Shared constants for the writeback-side register file.
// Holds the data width, register count and the architecturally special indices.
package regfile_wb_read_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int IDX_W    = 5;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [IDX_W-1:0]  regIdx_t;

    // $r0 is hardwired to zero, $r30 holds exception status, $r31 is the jal link target
    localparam regIdx_t REG_ZERO    = 5'd0;
    localparam regIdx_t REG_RSTATUS = 5'd30;
    localparam regIdx_t REG_RA      = 5'd31;

endpackage

// File: rtl/regfile_wb_read_reg32.sv
// One register of the file: a DATA_W-wide flop bank with load enable and
// synchronous active-high clear. Clear takes priority over load.
module reg32
    import regfile_wb_read_pkg::*;
(
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    // Hold the stored word; clear wins over a load arriving in the same cycle
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/regfile_wb_read.sv
// Architectural register file between the write stage and decode.
// One general write port, one dedicated $r30 (rstatus) write port, two
// combinational read ports and a registered rstatus view.
// Optional feature: define WB_BYPASS_EN to forward same-cycle write data to
// the read ports so decode needs no stall on a writeback/read match.
module regfile_wb_read
    import regfile_wb_read_pkg::*;
(
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              ctrl_writeEnable,
    input  logic [IDX_W-1:0]  ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic              ctrl_writeStatus,
    input  logic [DATA_W-1:0] data_writeStatusReg,
    input  logic [IDX_W-1:0]  ctrl_readRegA,
    input  logic [IDX_W-1:0]  ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB,
    output logic [DATA_W-1:0] data_rstatus
);

    logic [DATA_W-1:0] w_regs [NUM_REGS];

    // $r0 has no storage at all
    assign w_regs[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            localparam regIdx_t LIDX = IDX_W'(gi);

            logic              w_genHit;
            logic              w_statusHit;
            logic              w_en;
            logic [DATA_W-1:0] w_d;

            // The status port only ever targets $r30 and beats the general port there
            assign w_genHit    = ctrl_writeEnable && (ctrl_writeReg == LIDX);
            assign w_statusHit = ctrl_writeStatus && (LIDX == REG_RSTATUS);
            assign w_en        = w_genHit || w_statusHit;
            assign w_d         = w_statusHit ? data_writeStatusReg : data_writeReg;

            reg32 u_reg (
                .clock   (clock),
                .i_reset (ctrl_reset),
                .i_en    (w_en),
                .i_d     (w_d),
                .o_q     (w_regs[gi])
            );
        end
    endgenerate

    // Read port A: stored value, optionally overridden by a same-cycle write
    always_comb begin
        data_readRegA = w_regs[ctrl_readRegA];
`ifdef WB_BYPASS_EN
        if (!ctrl_reset) begin
            if (ctrl_writeStatus && (ctrl_readRegA == REG_RSTATUS)) begin
                data_readRegA = data_writeStatusReg;
            end else if (ctrl_writeEnable && (ctrl_readRegA == ctrl_writeReg) &&
                         (ctrl_readRegA != REG_ZERO)) begin
                data_readRegA = data_writeReg;
            end
        end
`endif
    end

    // Read port B: identical selection to port A
    always_comb begin
        data_readRegB = w_regs[ctrl_readRegB];
`ifdef WB_BYPASS_EN
        if (!ctrl_reset) begin
            if (ctrl_writeStatus && (ctrl_readRegB == REG_RSTATUS)) begin
                data_readRegB = data_writeStatusReg;
            end else if (ctrl_writeEnable && (ctrl_readRegB == ctrl_writeReg) &&
                         (ctrl_readRegB != REG_ZERO)) begin
                data_readRegB = data_writeReg;
            end
        end
`endif
    end

    // Branch-on-exception logic sees only committed state, never the bypass
    assign data_rstatus = w_regs[REG_RSTATUS];

endmodule
